audio_fft_framer: RTL and testbench

Frame builder that drives the sink side of the audio FFT core. It takes a free-running mono PCM sample stream with no backpressure, buffers it in an internal FIFO, and emits complete FFT_PTS-sample frames on an Avalon-ST style source. Each frame carries sop/eop, a real part sign-extended to 18 bits, a zero imaginary part and a constant point count. It sits between the audio codec deserialiser and the FFT core.

---
 rtl/audio_fft_framer.sv | 129 ++++++++++++
 tb/tb_audio_fft_framer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fft_framer.sv
// Frame builder for the audio FFT core: buffers a free-running PCM stream in a
// FIFO and emits complete FFT_PTS-sample frames on an Avalon-ST style source.
module audio_fft_framer #(
   parameter int FFT_PTS  = 256,
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 512
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                audio_valid,
   input  logic [SAMPLE_W-1:0] audio_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_sop,
   output logic                out_eop,
   output logic [17:0]         out_real,
   output logic [17:0]         out_imag,
   output logic [1:0]          out_error,
   output logic [10:0]         out_fftpts,
   output logic                out_inverse,
   output logic                overflow,
   output logic [15:0]         frames_sent
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(FFT_PTS);
   localparam logic [IW-1:0] LAST_IDX = IW'(FFT_PTS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

   state_t            state, state_next;
   logic [17:0]       mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [IW-1:0]     idx, idx_next;
   logic              xfer, last, frame_ready, full;
   logic              pop, frame_done, wr_en;
   logic signed [17:0] sample_ext;

   assign sample_ext  = 18'(signed'(audio_data));
   assign xfer        = out_valid && out_ready;
   assign last        = (idx == LAST_IDX);
   assign frame_ready = (count >= CW'(FFT_PTS));
   assign full        = (count == CW'(DEPTH));

   // At full a write only gets in when a pop frees a slot in the same cycle.
   assign wr_en = audio_valid && (!full || pop);

   assign out_imag    = 18'd0;
   assign out_error   = 2'b00;
   assign out_fftpts  = 11'(FFT_PTS);
   assign out_inverse = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_ready) state_next = LOAD;
         LOAD:    state_next = STREAM;
         STREAM:  if (xfer && last) state_next = frame_ready ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pop        = 1'b0;
      frame_done = 1'b0;
      idx_next   = idx;
      case (state)
         LOAD: pop = 1'b1;
         STREAM: begin
            if (xfer && last) begin
               frame_done = 1'b1;
            end else if (xfer) begin
               pop      = 1'b1;
               idx_next = idx + IW'(1);
            end
         end
         default: ;
      endcase
   end

   // NOTE: the sample store has no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) mem[wr_ptr] <= sample_ext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         idx         <= '0;
         out_valid   <= 1'b0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_real    <= '0;
         overflow    <= 1'b0;
         frames_sent <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_en) - CW'(pop);
         if (audio_valid && !wr_en) overflow <= 1'b1;

         if (pop) begin
            out_real  <= mem[rd_ptr];
            out_valid <= 1'b1;
            out_sop   <= (idx_next == '0);
            out_eop   <= (idx_next == LAST_IDX);
            idx       <= idx_next;
         end else if (frame_done) begin
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            idx         <= '0;
            frames_sent <= frames_sent + 16'd1;
         end else if (state == IDLE) begin
            idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_audio_fft_framer.sv
// Directed bench for audio_fft_framer with FFT_PTS=8, DEPTH=16: table-driven
// frames plus hand-written backpressure, overflow, reset and back-to-back runs.
module tb_audio_fft_framer;

   localparam int FFT_PTS  = 8;
   localparam int SAMPLE_W = 16;
   localparam int DEPTH    = 16;

   logic                clk;
   logic                reset;
   logic                audio_valid;
   logic [SAMPLE_W-1:0] audio_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_sop;
   logic                out_eop;
   logic [17:0]         out_real;
   logic [17:0]         out_imag;
   logic [1:0]          out_error;
   logic [10:0]         out_fftpts;
   logic                out_inverse;
   logic                overflow;
   logic [15:0]         frames_sent;

   audio_fft_framer #(.FFT_PTS(FFT_PTS), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .audio_valid(audio_valid), .audio_data(audio_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
      .out_real(out_real), .out_imag(out_imag), .out_error(out_error),
      .out_fftpts(out_fftpts), .out_inverse(out_inverse), .overflow(overflow),
      .frames_sent(frames_sent)
   );

   typedef struct {
      logic [15:0] din;
      logic [17:0] exp_real;
      logic        exp_sop;
      logic        exp_eop;
   } vec_t;

   typedef struct {
      logic [17:0] r;
      logic        sop;
      logic        eop;
   } xfer_t;

   vec_t  vecs [16];
   xfer_t q [$];
   int    gaps [$];
   int    n_checks = 0;
   int    n_pass   = 0;

   logic  held = 1'b0;
   xfer_t held_x;
   logic  after_eop = 1'b0;
   int    gap = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Transfer recorder and stall-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         held      = 1'b0;
         after_eop = 1'b0;
         gap       = 0;
      end else begin
         if (held) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_real", 32'(out_real), 32'(held_x.r));
            check("stall_sop", 32'(out_sop), 32'(held_x.sop));
            check("stall_eop", 32'(out_eop), 32'(held_x.eop));
         end
         if (after_eop && out_valid) begin
            gaps.push_back(gap);
            after_eop = 1'b0;
         end else if (after_eop) begin
            gap++;
         end
         if (out_valid && out_ready) begin
            q.push_back('{r: out_real, sop: out_sop, eop: out_eop});
            if (out_eop) begin
               after_eop = 1'b1;
               gap       = 0;
            end
            held = 1'b0;
         end else if (out_valid) begin
            held   = 1'b1;
            held_x = '{r: out_real, sop: out_sop, eop: out_eop};
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      q.delete();
      gaps.delete();
   endtask

   task automatic write_sample(input logic [15:0] d);
      audio_valid = 1'b1;
      audio_data  = d;
      tick(1);
      audio_valid = 1'b0;
   endtask

   task automatic wait_xfers(input int n);
      int budget = 400;
      while (q.size() < n && budget > 0) begin
         tick(1);
         budget--;
      end
      if (q.size() < n) check("xfer_timeout", 32'(q.size()), 32'(n));
   endtask

   // Compares recorded transfers against a counting sequence start, start+1, ...
   task automatic check_count_frames(input int n, input int start, input string tag);
      for (int i = 0; i < n; i++) begin
         if (i < q.size()) begin
            check({tag, "_real"}, 32'(q[i].r), 32'(start + i));
            check({tag, "_sop"}, 32'(q[i].sop), 32'(i % FFT_PTS == 0));
            check({tag, "_eop"}, 32'(q[i].eop), 32'(i % FFT_PTS == FFT_PTS - 1));
         end
      end
   endtask

   initial begin
      vecs[0]  = '{16'h0001, 18'h00001, 1'b1, 1'b0};
      vecs[1]  = '{16'h0002, 18'h00002, 1'b0, 1'b0};
      vecs[2]  = '{16'h0003, 18'h00003, 1'b0, 1'b0};
      vecs[3]  = '{16'h0004, 18'h00004, 1'b0, 1'b0};
      vecs[4]  = '{16'h0005, 18'h00005, 1'b0, 1'b0};
      vecs[5]  = '{16'h0006, 18'h00006, 1'b0, 1'b0};
      vecs[6]  = '{16'h0007, 18'h00007, 1'b0, 1'b0};
      vecs[7]  = '{16'h0008, 18'h00008, 1'b0, 1'b1};
      vecs[8]  = '{16'h8000, 18'h38000, 1'b1, 1'b0};
      vecs[9]  = '{16'h7FFF, 18'h07FFF, 1'b0, 1'b0};
      vecs[10] = '{16'hFFFF, 18'h3FFFF, 1'b0, 1'b0};
      vecs[11] = '{16'h0001, 18'h00001, 1'b0, 1'b0};
      vecs[12] = '{16'h1234, 18'h01234, 1'b0, 1'b0};
      vecs[13] = '{16'hC000, 18'h3C000, 1'b0, 1'b0};
      vecs[14] = '{16'h0000, 18'h00000, 1'b0, 1'b0};
      vecs[15] = '{16'h8001, 18'h38001, 1'b0, 1'b1};

      audio_valid = 1'b0;
      audio_data  = '0;
      out_ready   = 1'b1;
      reset       = 1'b0;
      tick(1);
      do_reset();

      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sop", 32'(out_sop), 32'd0);
      check("rst_eop", 32'(out_eop), 32'd0);
      check("rst_real", 32'(out_real), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_frames", 32'(frames_sent), 32'd0);
      check("const_imag", 32'(out_imag), 32'd0);
      check("const_error", 32'(out_error), 32'd0);
      check("const_fftpts", 32'(out_fftpts), 32'd8);
      check("const_inverse", 32'(out_inverse), 32'd0);

      // Table frames: plain counting frame, then the sign-extension frame.
      for (int f = 0; f < 2; f++) begin
         q.delete();
         for (int i = 0; i < FFT_PTS; i++) write_sample(vecs[f*FFT_PTS + i].din);
         wait_xfers(FFT_PTS);
         tick(3);
         for (int i = 0; i < FFT_PTS; i++) begin
            if (i < q.size()) begin
               check("tbl_real", 32'(q[i].r), 32'(vecs[f*FFT_PTS + i].exp_real));
               check("tbl_sop", 32'(q[i].sop), 32'(vecs[f*FFT_PTS + i].exp_sop));
               check("tbl_eop", 32'(q[i].eop), 32'(vecs[f*FFT_PTS + i].exp_eop));
            end
         end
         check("tbl_count", 32'(q.size()), 32'(FFT_PTS));
         check("tbl_frames", 32'(frames_sent), 32'(f + 1));
         check("tbl_overflow", 32'(overflow), 32'd0);
      end
      check("tbl_imag", 32'(out_imag), 32'd0);
      check("tbl_fftpts", 32'(out_fftpts), 32'd8);

      // Backpressure: out_ready cycles 1,0,0,1 while a frame streams out.
      do_reset();
      fork
         begin
            for (int i = 0; i < FFT_PTS; i++) write_sample(16'(i + 1));
         end
         begin
            for (int c = 0; c < 60; c++) begin
               out_ready = (c % 4 == 0) || (c % 4 == 3);
               tick(1);
            end
         end
      join
      out_ready = 1'b1;
      wait_xfers(FFT_PTS);
      tick(3);
      check_count_frames(FFT_PTS, 1, "bp");
      check("bp_count", 32'(q.size()), 32'(FFT_PTS));
      check("bp_frames", 32'(frames_sent), 32'd1);

      // Overflow: with the sink stalled, sample 1 sits in the output register
      // and 2..17 fill the FIFO, so 18..20 are dropped.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) write_sample(16'(i + 1));
      tick(2);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_frames_stalled", 32'(frames_sent), 32'd0);
      check("ovf_head_real", 32'(out_real), 32'd1);
      check("ovf_head_sop", 32'(out_sop), 32'd1);
      out_ready = 1'b1;
      wait_xfers(2 * FFT_PTS);
      tick(20);
      check_count_frames(2 * FFT_PTS, 1, "ovf");
      check("ovf_count", 32'(q.size()), 32'(2 * FFT_PTS));
      check("ovf_frames", 32'(frames_sent), 32'd2);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Reset mid-frame: sample 17 is still buffered, so a frame starts early.
      q.delete();
      for (int i = 0; i < FFT_PTS; i++) write_sample(16'(101 + i));
      wait_xfers(3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_frames", 32'(frames_sent), 32'd0);
      check("mid_overflow", 32'(overflow), 32'd0);
      tick(3);
      check("mid_idle", 32'(out_valid), 32'd0);
      q.delete();
      for (int i = 0; i < FFT_PTS; i++) write_sample(16'(201 + i));
      wait_xfers(FFT_PTS);
      tick(3);
      check_count_frames(FFT_PTS, 201, "mid");
      check("mid_frames_after", 32'(frames_sent), 32'd1);

      // Back-to-back: three frames, one idle cycle between eop and next sop.
      do_reset();
      for (int i = 0; i < 3 * FFT_PTS; i++) write_sample(16'(i + 1));
      wait_xfers(3 * FFT_PTS);
      tick(5);
      check_count_frames(3 * FFT_PTS, 1, "b2b");
      check("b2b_frames", 32'(frames_sent), 32'd3);
      check("b2b_gap_count", 32'(gaps.size()), 32'd2);
      foreach (gaps[i]) check("b2b_gap", 32'(gaps[i]), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
